// File: rtl/seq_reader_8x4.sv
// seq_reader_8x4: circular 4-bit sequence store with valid/ready replay.
// Define SEQ_READER_CLEAR_ON_READ_EN to make a completed replay destructive.
module seq_reader_8x4 #(
  parameter int DEPTH = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       push,
  input  logic [3:0] push_data,
  input  logic       start,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_data,
  output logic [3:0] count,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       done,
  output logic       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] FULL_CNT = 4'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_idx;
  logic [3:0]    sent;

  logic          push_ok;
  logic          start_ok;
  logic          xfer;
  logic          last;
  logic [3:0]    cnt_p;
  logic [AW-1:0] wptr_p;

  always_comb begin
    push_ok  = 1'b0;
    start_ok = 1'b0;
    xfer     = 1'b0;
    last     = 1'b0;
    cnt_p    = count;
    wptr_p   = wr_ptr;
    if (state == IDLE) begin
      push_ok  = push;
      start_ok = start;
    end
    if (push_ok) begin
      wptr_p = wr_ptr + AW'(1);
      if (count != FULL_CNT)
        cnt_p = count + 4'd1;
    end
    if (state == READ) begin
      xfer = out_ready;
      last = out_ready && ((sent + 4'd1) == count);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start_ok)
          state_next = (cnt_p != 4'd0) ? READ : DONE;
      end
      READ: begin
        if (last)
          state_next = DONE;
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state == READ);
    busy      = (state == READ);
    done      = (state == DONE);
    out_data  = out_valid ? mem[rd_idx] : 4'd0;
    full      = (count == FULL_CNT);
    empty     = (count == 4'd0);
  end

  // Start may share a cycle with a push; the replay origin uses post-push state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= 4'd0;
      wr_ptr   <= '0;
      rd_idx   <= '0;
      sent     <= 4'd0;
      count    <= 4'd0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wptr_p;
        count       <= cnt_p;
        if (count == FULL_CNT)
          overflow <= 1'b1;
      end
      if (start_ok) begin
        rd_idx <= wptr_p - cnt_p[AW-1:0];
        sent   <= 4'd0;
      end
      if (xfer) begin
        rd_idx <= rd_idx + AW'(1);
        sent   <= sent + 4'd1;
      end
`ifdef SEQ_READER_CLEAR_ON_READ_EN
      if (state_next == DONE && state != DONE) begin
        count    <= 4'd0;
        overflow <= 1'b0;
      end
`endif
    end
  end

endmodule
